bft_leaf_egress_buffer: RTL and testbench

- Sits directly downstream of a leaf shell's packet output (dout_leaf_interface2bft) and upstream of the BFT switch leaf port.
- Buffers outgoing 49-bit BFT packets in a FIFO and presents them one at a time with a hold-until-ack handshake.
- Blanks its output while resend is asserted, and reports overflow and occupancy back to the leaf side.

---
 rtl/bft_leaf_egress_buffer.sv | 155 +++++++++++++++
 tb/tb_bft_leaf_egress_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bft_leaf_egress_buffer.sv
// Egress buffer between a leaf shell and its BFT switch leaf port.
// A FIFO plus one output register; the output is held until acknowledged.
//
// Ports:
//   clk, reset_n            clock and async active-low reset
//   din_leaf_interface2bft  packet in (MSB = valid)
//   stall_bft2interface     almost-full indication (registered)
//   dout_egress2bft         packet out, all zeros when idle or during resend
//   ack_bft2egress          switch accepts the packet on dout
//   resend                  blank dout and ignore acks
//   overflow                sticky drop flag
//   clear_overflow          clears overflow (and drop_cnt)
//   occupancy               packets held, output register included
//   drop_cnt                saturating drop count, built only with
//                           BFT_EGRESS_DROP_CNT_EN
module bft_leaf_egress_buffer #(
  parameter int PACKET_BITS  = 49,
  parameter int DEPTH_BITS   = 5,
  parameter int STALL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PACKET_BITS-1:0] din_leaf_interface2bft,
  output logic                   stall_bft2interface,
  output logic [PACKET_BITS-1:0] dout_egress2bft,
  input  logic                   ack_bft2egress,
  input  logic                   resend,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [DEPTH_BITS:0]    occupancy
`ifdef BFT_EGRESS_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int CAP   = 1 << DEPTH_BITS;
  localparam int SLOTS = CAP - 1;

  localparam logic [DEPTH_BITS:0] CAP_V =
    (DEPTH_BITS+1)'(CAP);
  localparam logic [DEPTH_BITS:0] MARGIN_V =
    (DEPTH_BITS+1)'(STALL_MARGIN);
  localparam logic [DEPTH_BITS-1:0] LAST =
    DEPTH_BITS'(SLOTS - 1);

  logic [PACKET_BITS-1:0] mem [SLOTS];
  logic [DEPTH_BITS-1:0]  wr_ptr;
  logic [DEPTH_BITS-1:0]  rd_ptr;
  logic [DEPTH_BITS-1:0]  fifo_cnt;
  logic                   out_vld;
  logic [PACKET_BITS-1:0] out_q;
  logic                   stall_q;
  logic                   ovf_q;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   accept;
  logic                   drop;
  logic                   load;
  logic                   fifo_rd;
  logic                   fifo_wr;
  logic                   bypass;
  logic [DEPTH_BITS:0]    occ_nxt;

  function automatic logic [DEPTH_BITS-1:0] nxt(
    input logic [DEPTH_BITS-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign occupancy = {1'b0, fifo_cnt}
                   + {{DEPTH_BITS{1'b0}}, out_vld};

  assign push   = din_leaf_interface2bft[PACKET_BITS-1];
  assign pop    = out_vld & ack_bft2egress & ~resend;
  assign full   = (occupancy == CAP_V);
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Output register wants a packet when empty or being popped.
  // With an empty FIFO the incoming packet skips the FIFO.
  assign load    = ~out_vld | pop;
  assign fifo_rd = load & (fifo_cnt != '0);
  assign bypass  = load & (fifo_cnt == '0) & accept;
  assign fifo_wr = accept & ~bypass;

  assign occ_nxt = occupancy
                 + {{DEPTH_BITS{1'b0}}, accept}
                 - {{DEPTH_BITS{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= din_leaf_interface2bft;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_vld  <= 1'b0;
      out_q    <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_wr)
        wr_ptr <= nxt(wr_ptr);
      if (fifo_rd)
        rd_ptr <= nxt(rd_ptr);
      fifo_cnt <= fifo_cnt
                + DEPTH_BITS'(fifo_wr)
                - DEPTH_BITS'(fifo_rd);
      if (load) begin
        if (fifo_rd) begin
          out_q   <= mem[rd_ptr];
          out_vld <= 1'b1;
        end else if (bypass) begin
          out_q   <= din_leaf_interface2bft;
          out_vld <= 1'b1;
        end else begin
          out_q   <= '0;
          out_vld <= 1'b0;
        end
      end
      stall_q <= (CAP_V - occ_nxt) <= MARGIN_V;
      if (drop)
        ovf_q <= 1'b1;
      else if (clear_overflow)
        ovf_q <= 1'b0;
    end
  end

`ifdef BFT_EGRESS_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else if (clear_overflow)
      drop_q <= {15'd0, drop};
    else if (drop && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`endif

  assign dout_egress2bft =
    (out_vld & ~resend) ? out_q : '0;
  assign stall_bft2interface = stall_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bft_leaf_egress_buffer.sv
// Self-checking bench for bft_leaf_egress_buffer.
// Vector table, directed corner sequences and a queue-model random run.
module tb_bft_leaf_egress_buffer;

  localparam int PB  = 49;
  localparam int DB  = 5;
  localparam int CAP = 32;
  localparam int MRG = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PB-1:0] din = '0;
  logic          stall;
  logic [PB-1:0] dout;
  logic          ack = 1'b0;
  logic          resend = 1'b0;
  logic          ovf;
  logic          clr = 1'b0;
  logic [DB:0]   occ;
`ifdef BFT_EGRESS_DROP_CNT_EN
  logic [15:0]   dcnt;
`endif

  always #5 clk = ~clk;

  bft_leaf_egress_buffer #(
    .PACKET_BITS (PB),
    .DEPTH_BITS  (DB),
    .STALL_MARGIN(MRG)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .din_leaf_interface2bft(din),
    .stall_bft2interface   (stall),
    .dout_egress2bft       (dout),
    .ack_bft2egress        (ack),
    .resend                (resend),
    .overflow              (ovf),
    .clear_overflow        (clr),
    .occupancy             (occ)
`ifdef BFT_EGRESS_DROP_CNT_EN
    ,
    .drop_cnt              (dcnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [PB-1:0] q[$];
  logic          m_ovf = 1'b0;
  int            m_dcnt = 0;
  logic          m_stall = 1'b0;

  typedef struct {
    logic [PB-1:0] d;
    logic          a;
    logic          r;
    logic [PB-1:0] e_dout;
    int            e_occ;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [PB-1:0] pkt(input logic [47:0] v);
    return {1'b1, v};
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] m_dout();
    if (q.size() > 0 && !resend)
      return q[0];
    return '0;
  endfunction

  task automatic model_edge();
    bit p_pop;
    bit p_push;
    bit p_full;
    p_pop  = (q.size() > 0) && ack && !resend;
    p_push = din[PB-1];
    p_full = (q.size() == CAP);
    if (p_push && p_full && !p_pop) begin
      m_ovf = 1'b1;
      if (clr)
        m_dcnt = 1;
      else if (m_dcnt < 65535)
        m_dcnt++;
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end
    if (p_pop)
      void'(q.pop_front());
    if (p_push && (!p_full || p_pop))
      q.push_back(din);
    m_stall = (CAP - q.size()) <= MRG;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_dcnt  = 0;
    m_stall = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, 64'(dout), 64'(m_dout()));
    check({tag, ".occ"}, 64'(occ), 64'(q.size()));
    check({tag, ".stall"}, 64'(stall), 64'(m_stall));
    check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
`ifdef BFT_EGRESS_DROP_CNT_EN
    check({tag, ".dcnt"}, 64'(dcnt), 64'(m_dcnt));
`endif
  endtask

  task automatic step(input logic [PB-1:0] d,
                      input logic a,
                      input logic r,
                      input logic c,
                      input string tag);
    @(negedge clk);
    din = d;
    ack = a;
    resend = r;
    clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    din = '0;
    ack = 1'b0;
    resend = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all("reset");
  endtask

  initial begin
    logic [PB-1:0] p;
    logic [PB-1:0] a_pkt;
    logic [PB-1:0] b_pkt;
    p     = pkt(48'h0000_1234_5678);
    a_pkt = pkt(48'hA);
    b_pkt = pkt(48'hB);

    tbl[0]  = '{p,     1'b0, 1'b0, p,     1};
    tbl[1]  = '{'0,    1'b0, 1'b0, p,     1};
    tbl[2]  = '{'0,    1'b1, 1'b0, '0,    0};
    tbl[3]  = '{a_pkt, 1'b0, 1'b0, a_pkt, 1};
    tbl[4]  = '{b_pkt, 1'b1, 1'b1, '0,    2};
    tbl[5]  = '{'0,    1'b1, 1'b1, '0,    2};
    tbl[6]  = '{'0,    1'b0, 1'b1, '0,    2};
    tbl[7]  = '{'0,    1'b1, 1'b1, '0,    2};
    tbl[8]  = '{'0,    1'b0, 1'b1, '0,    2};
    tbl[9]  = '{'0,    1'b0, 1'b0, a_pkt, 2};
    tbl[10] = '{'0,    1'b1, 1'b0, b_pkt, 1};
    tbl[11] = '{'0,    1'b1, 1'b0, '0,    0};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].d, tbl[i].a, tbl[i].r, 1'b0,
           $sformatf("vec%0d", i));
      check($sformatf("tbl%0d.dout", i),
            64'(dout), 64'(tbl[i].e_dout));
      check($sformatf("tbl%0d.occ", i),
            64'(occ), 64'(tbl[i].e_occ));
    end

    // burst with ack held high
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(pkt(48'(i)), 1'b1, 1'b0, 1'b0, "burst");
      check("burst.order", 64'(dout), 64'(pkt(48'(i))));
      check("burst.occ_le2", 64'(occ <= 2), 64'd1);
    end
    step('0, 1'b1, 1'b0, 1'b0, "burst_end");
    check("burst.idle", 64'(dout), 64'd0);

    // fill to capacity, then overflow
    do_reset();
    for (int i = 1; i <= CAP; i++) begin
      step(pkt(48'(i)), 1'b0, 1'b0, 1'b0, "fill");
      check($sformatf("fill.stall%0d", i),
            64'(stall), 64'(i >= 28));
    end
    check("fill.occ", 64'(occ), 64'd32);
    step(pkt(48'h33), 1'b0, 1'b0, 1'b0, "drop");
    check("drop.ovf", 64'(ovf), 64'd1);
    check("drop.head", 64'(dout), 64'(pkt(48'd1)));
`ifdef BFT_EGRESS_DROP_CNT_EN
    check("drop.dcnt", 64'(dcnt), 64'd1);
`endif
    step('0, 1'b0, 1'b0, 1'b1, "clear");
    check("clear.ovf", 64'(ovf), 64'd0);
    step(pkt(48'h40), 1'b1, 1'b0, 1'b0, "full_pp");
    check("full_pp.occ", 64'(occ), 64'd32);
    check("full_pp.ovf", 64'(ovf), 64'd0);
    check("full_pp.head", 64'(dout), 64'(pkt(48'd2)));
    step(pkt(48'h41), 1'b0, 1'b0, 1'b1, "set_wins");
    check("set_wins.ovf", 64'(ovf), 64'd1);
`ifdef BFT_EGRESS_DROP_CNT_EN
    check("set_wins.dcnt", 64'(dcnt), 64'd1);
`endif
    for (int i = 0; i < CAP; i++)
      step('0, 1'b1, 1'b0, 1'b0, "drain");
    check("drain.occ", 64'(occ), 64'd0);

    // async reset mid-burst
    do_reset();
    for (int i = 0; i < 7; i++)
      step(pkt(48'(100 + i)), 1'b0, 1'b0, 1'b0, "pre_rst");
    check("pre_rst.occ", 64'(occ), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.dout", 64'(dout), 64'd0);
    check("arst.occ", 64'(occ), 64'd0);
    check("arst.stall", 64'(stall), 64'd0);
    model_reset();
    din = '0;
    @(negedge clk);
    reset_n = 1'b1;
    step(pkt(48'h77), 1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst.dout", 64'(dout), 64'(pkt(48'h77)));

    // randomized run against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [PB-1:0] d;
      int ph;
      int pp;
      int ap;
      ph = (i / 250) % 3;
      pp = (ph == 0) ? 90 : (ph == 1) ? 50 : 20;
      ap = (ph == 0) ? 15 : (ph == 1) ? 50 : 85;
      d = {1'b0, 16'($urandom), 32'($urandom)};
      d[PB-1] = ($urandom_range(99) < pp);
      step(d,
           $urandom_range(99) < ap,
           $urandom_range(99) < 10,
           $urandom_range(99) < 4,
           "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
